// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time loader: byte stream (count + words) into instr_mem, holds core until done
module prog_loader #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        err,
  output logic [31:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_idx;
  logic [31:0] shift_reg;
  logic [31:0] n_words;
  logic        xfer;
  logic        last_byte;
  logic [31:0] assembled;
  logic        enter_hdr;

  assign xfer      = s_valid & s_ready;
  assign last_byte = xfer && (byte_idx == 2'd3);
  // Bytes arrive LSB-first, so each new byte enters at the top and shifts down.
  assign assembled = {s_data, shift_reg[31:8]};
  assign enter_hdr = (state_nxt == S_HDR) && (state != S_HDR);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_HDR;
      S_HDR: if (last_byte) begin
        if (assembled == 32'd0 || assembled > 32'(DEPTH_WORDS)) state_nxt = S_ERR;
        else                                                     state_nxt = S_DATA;
      end
      S_DATA:  if (last_byte) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (words_loaded + 32'd1 == n_words) ? S_DONE : S_DATA;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      s_ready      <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= BASE_ADDR;
      im_wdata     <= 32'd0;
      core_hold    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= 32'd0;
      byte_idx     <= 2'd0;
      shift_reg    <= 32'd0;
      n_words      <= 32'd0;
    end else begin
      s_ready <= (state_nxt == S_HDR) || (state_nxt == S_DATA);
      im_we   <= (state_nxt == S_WRITE);

      if (xfer) begin
        shift_reg <= assembled;
        byte_idx  <= byte_idx + 2'd1;
      end
      if (state == S_HDR && last_byte) n_words <= assembled;

      if (state_nxt == S_WRITE && state != S_WRITE) begin
        im_addr  <= BASE_ADDR + (words_loaded << 2);
        im_wdata <= assembled;
      end
      if (state == S_WRITE) words_loaded <= words_loaded + 32'd1;

      if (state_nxt == S_DONE && state != S_DONE) begin
        done      <= 1'b1;
        core_hold <= 1'b0;
      end
      if (state_nxt == S_ERR && state != S_ERR) err <= 1'b1;

      if (enter_hdr) begin
        done         <= 1'b0;
        err          <= 1'b0;
        words_loaded <= 32'd0;
        byte_idx     <= 2'd0;
        core_hold    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready, im_we, core_hold, done, err;
  logic [31:0] im_addr, im_wdata, words_loaded;

  prog_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .areset(areset), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .core_hold(core_hold), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int   gap_max = 0;
  logic noise = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every write pulse is matched against the oldest expected write.
  always @(negedge clk) begin
    if (!areset && im_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", im_addr, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", im_addr, mon_e.addr);
        check("wr_data", im_wdata, mon_e.data);
        check("wr_s_ready_low", {31'd0, s_ready}, 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int cnt;
    if (gap_max > 0) begin
      gap = $urandom_range(gap_max, 0);
      s_valid = 1'b0;
      for (int i = 0; i < gap; i++) begin
        if (noise && i == 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    cnt = 0;
    while (!s_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!s_ready) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_field(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w, input int k);
    wr_t e;
    e.addr = 32'(4 * k);
    e.data = w;
    exp_q.push_back(e);
    send_field(w);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int cnt = 0;
    s_valid = 1'b0;
    while (!done && !err && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (!done && !err) check({name, "_end_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    check({name, "_im_we"}, {31'd0, im_we}, 32'd0);
    check({name, "_im_addr"}, im_addr, 32'd0);
    check({name, "_im_wdata"}, im_wdata, 32'd0);
    check({name, "_core_hold"}, {31'd0, core_hold}, 32'd1);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_err"}, {31'd0, err}, 32'd0);
    check({name, "_words"}, words_loaded, 32'd0);
  endtask

  logic [31:0] wv [0:2];
  int start_cyc;
  int cnt;

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    areset = 1'b0;
    @(negedge clk);

    // 1: single word, explicit bytes
    pulse_start();
    begin
      wr_t e;
      e.addr = 32'h0; e.data = 32'h0050_0513;
      exp_q.push_back(e);
    end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h50); send_byte(8'h00);
    wait_end("t1");
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_core_hold", {31'd0, core_hold}, 32'd0);
    check("t1_words", words_loaded, 32'd1);

    // 2: N=3 back-to-back, timing of done
    pulse_start();
    start_cyc = cyc;
    send_field(32'd3);
    send_word(32'hA, 0); send_word(32'hB, 1); send_word(32'hC, 2);
    wait_end("t2");
    check("t2_done_latency", 32'(cyc - start_cyc), 32'd19);
    check("t2_words", words_loaded, 32'd3);

    // 3: rejected headers
    pulse_start();
    send_field(32'd0);
    wait_end("t3a");
    check("t3a_err", {31'd0, err}, 32'd1);
    check("t3a_core_hold", {31'd0, core_hold}, 32'd1);
    check("t3a_done", {31'd0, done}, 32'd0);
    pulse_start();
    check("t3b_err_cleared", {31'd0, err}, 32'd0);
    send_field(32'd65);
    wait_end("t3b");
    check("t3b_err", {31'd0, err}, 32'd1);
    check("t3b_core_hold", {31'd0, core_hold}, 32'd1);
    repeat (3) @(negedge clk);

    // 4: random gaps plus stray start pulses
    wv[0] = 32'hDEAD_BEEF; wv[1] = 32'h1234_5678; wv[2] = 32'hCAFE_F00D;
    pulse_start();
    gap_max = 4;
    noise = 1'b1;
    send_field(32'd3);
    for (int k = 0; k < 3; k++) send_word(wv[k], k);
    gap_max = 0;
    noise = 1'b0;
    wait_end("t4");
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_words", words_loaded, 32'd3);

    // 5: reset after 2 of 3 words
    pulse_start();
    send_field(32'd3);
    send_word(32'h1111_2222, 0); send_word(32'h3333_4444, 1);
    s_valid = 1'b0;
    cnt = 0;
    while (words_loaded != 32'd2 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("t5_two_written", words_loaded, 32'd2);
    #2 areset = 1'b1;
    #1 check_reset_vals("t5_async");
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    pulse_start();
    send_field(32'd1);
    send_word(32'h5555_6666, 0);
    wait_end("t5b");
    check("t5b_done", {31'd0, done}, 32'd1);
    check("t5b_words", words_loaded, 32'd1);

    // 6: reload from DONE
    pulse_start();
    check("t6_hold_first_hdr", {31'd0, core_hold}, 32'd1);
    check("t6_done_first_hdr", {31'd0, done}, 32'd0);
    check("t6_words_first_hdr", words_loaded, 32'd0);
    check("t6_ready_first_hdr", {31'd0, s_ready}, 32'd1);
    send_field(32'd2);
    send_word(32'h7777_8888, 0); send_word(32'h9999_AAAA, 1);
    wait_end("t6");
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_words", words_loaded, 32'd2);
    check("t6_core_hold", {31'd0, core_hold}, 32'd0);

    repeat (2) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
